// File: rtl/tx_frame_fetch_if.sv
// RAM read port and transmitter byte handshake used by tx_frame_fetch.
// master is the fetch engine's view; slave is the RAM/transmitter side.
interface tx_frame_fetch_if;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data;
   logic [7:0]  data;
   logic        has_data;
   logic        ack_data;
   logic        is_crc_byte;
   logic        is_last_byte;
   logic [15:0] crc_data;
   logic        cd;
   logic        err;

   modport master (
      output rd_en, rd_addr, data, has_data, is_crc_byte, is_last_byte,
      input  rd_data, ack_data, crc_data, cd, err
   );

   modport slave (
      input  rd_en, rd_addr, data, has_data, is_crc_byte, is_last_byte,
      output rd_data, ack_data, crc_data, cd, err
   );
endinterface

// File: rtl/tx_frame_fetch.sv
// Streams one buffered CDBUS frame (src, dst, len, payload) to the serial
// transmitter, appends its running CRC, and handles retry/drop.
module tx_frame_fetch #(
   parameter int MAX_LEN   = 253,
   parameter int MAX_RETRY = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_valid,
   input  logic             abort,
   output logic             frame_done,
   output logic             frame_drop,
   output logic [2:0]       retry_cnt,
   tx_frame_fetch_if.master bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] SEND  = 3'd2;
   localparam logic [2:0] CRC_L = 3'd3;
   localparam logic [2:0] CRC_H = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
   localparam logic [2:0] MAX_RETRY_B = 3'(MAX_RETRY);

   logic [2:0] state;
   logic [8:0] idx;
   logic [7:0] len;
   logic [7:0] data_q;
   logic       rd_en_q;
   logic       rd_valid;
   logic       has_data_q;
   logic       is_crc_q;
   logic       is_last_q;
   logic       new_frame;
   logic       active;
   logic [8:0] last_idx;
   logic [7:0] len_clamped;

   assign active      = state inside {FETCH, SEND, CRC_L, CRC_H};
   // 9-bit so that len=253 gives a last frame byte at address 255 without wrap.
   assign last_idx    = {1'b0, len} + 9'd2;
   assign len_clamped = (bus.rd_data > MAX_LEN_B) ? MAX_LEN_B : bus.rd_data;

   assign bus.rd_en        = rd_en_q;
   assign bus.rd_addr      = idx[7:0];
   assign bus.has_data     = has_data_q;
   assign bus.is_crc_byte  = is_crc_q;
   assign bus.is_last_byte = is_last_q;
   // CRC bytes come straight from the transmitter, which freezes it while is_crc_byte is high.
   assign bus.data = is_crc_q ? (is_last_q ? bus.crc_data[15:8] : bus.crc_data[7:0]) : data_q;

   // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         len        <= '0;
         data_q     <= '0;
         rd_en_q    <= 1'b0;
         rd_valid   <= 1'b0;
         has_data_q <= 1'b0;
         is_crc_q   <= 1'b0;
         is_last_q  <= 1'b0;
         frame_done <= 1'b0;
         frame_drop <= 1'b0;
         retry_cnt  <= '0;
         new_frame  <= 1'b1;
      end else begin
         rd_en_q    <= 1'b0;
         rd_valid   <= rd_en_q;
         frame_done <= 1'b0;
         frame_drop <= 1'b0;

         if (active && (abort || bus.err)) begin
            has_data_q <= 1'b0;
            is_crc_q   <= 1'b0;
            is_last_q  <= 1'b0;
            rd_valid   <= 1'b0;
            frame_drop <= 1'b1;
            state      <= DONE;
         end else if (active && bus.cd) begin
            has_data_q <= 1'b0;
            is_crc_q   <= 1'b0;
            is_last_q  <= 1'b0;
            rd_valid   <= 1'b0;
            idx        <= '0;
            if (retry_cnt == MAX_RETRY_B) begin
               frame_drop <= 1'b1;
               state      <= DONE;
            end else begin
               retry_cnt <= retry_cnt + 3'd1;
               state     <= IDLE;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (frame_valid && !abort) begin
                     rd_en_q <= 1'b1;
                     state   <= FETCH;
                     // A cd restart re-enters here too; only a fresh frame clears the count.
                     if (new_frame) begin
                        retry_cnt <= '0;
                        new_frame <= 1'b0;
                     end
                  end
               end
               FETCH: begin
                  if (rd_valid) begin
                     data_q     <= bus.rd_data;
                     has_data_q <= 1'b1;
                     state      <= SEND;
                  end
               end
               SEND: begin
                  if (rd_valid) begin
                     data_q <= bus.rd_data;
                     if (idx == 9'd2) len <= len_clamped;
                  end
                  if (bus.ack_data) begin
                     idx <= idx + 9'd1;
                     if (idx == last_idx) begin
                        is_crc_q <= 1'b1;
                        state    <= CRC_L;
                     end else begin
                        rd_en_q <= 1'b1;
                     end
                  end
               end
               CRC_L: begin
                  if (bus.ack_data) begin
                     is_last_q <= 1'b1;
                     state     <= CRC_H;
                  end
               end
               CRC_H: begin
                  if (bus.ack_data) begin
                     frame_done <= 1'b1;
                     has_data_q <= 1'b0;
                     is_crc_q   <= 1'b0;
                     is_last_q  <= 1'b0;
                     state      <= DONE;
                  end
               end
               DONE: begin
                  if (!frame_valid) begin
                     idx       <= '0;
                     new_frame <= 1'b1;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
